// File: rtl/button_pkg.sv
// button_pkg: shared FSM state type, default 50 MHz cycle counts and counter-width helper
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REPEATING
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_HOLD_CYCLES     = 50000000;
  localparam int DEF_REPEAT_CYCLES   = 10000000;

  // $clog2(1) is 0, so a one-cycle period still gets a 1-bit counter
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_sync_debounce.sv
// button_sync_debounce: two-flop synchroniser plus debounce counter; clk/reset/button in, clean level and its one-cycle rise/fall markers out
module button_sync_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic clean,
  output logic clean_rise,
  output logic clean_fall
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic s1_q, s2_q;
  logic clean_q, clean_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic flip;

  // rise/fall are combinational so the top can register its strobes on the same edge clean toggles
  always_comb begin
    flip    = (s2_q != clean_q) && (dcnt_q == D_LAST);
    clean_d = flip ? ~clean_q : clean_q;
    dcnt_d  = (s2_q == clean_q || flip) ? '0 : dcnt_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      clean_q <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      s1_q    <= button;
      s2_q    <= s1_q;
      clean_q <= clean_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign clean      = clean_q;
  assign clean_rise = flip & ~clean_q;
  assign clean_fall = flip & clean_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced button level with registered press/release/auto-repeat strobes, long_press flag and step (press|repeat)
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic clean,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_press,
  output logic step
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

  logic rise, fall;

  button_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .clean     (clean),
    .clean_rise(rise),
    .clean_fall(fall)
  );

  state_e state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic repeat_q, repeat_d;
  logic long_q, long_d;
  logic step_q, step_d;

  // fall is checked before the repeat terminal so a colliding release suppresses the repeat
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    rcnt_d    = rcnt_q;
    long_d    = long_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        state_d = PRESSED;
        press_d = 1'b1;
        hcnt_d  = '0;
      end
      PRESSED: if (fall) begin
        state_d   = IDLE;
        release_d = 1'b1;
        long_d    = 1'b0;
        hcnt_d    = '0;
        rcnt_d    = '0;
      end else if (hcnt_q == H_LAST) begin
        state_d  = REPEATING;
        repeat_d = 1'b1;
        long_d   = 1'b1;
        rcnt_d   = '0;
      end else hcnt_d = hcnt_q + HW'(1);
      REPEATING: if (fall) begin
        state_d   = IDLE;
        release_d = 1'b1;
        long_d    = 1'b0;
        hcnt_d    = '0;
        rcnt_d    = '0;
      end else if (rcnt_q == R_LAST) begin
        repeat_d = 1'b1;
        rcnt_d   = '0;
      end else rcnt_d = rcnt_q + RW'(1);
      default: state_d = IDLE;
    endcase
    step_d = press_d | repeat_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      long_q    <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      rcnt_q    <= rcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      long_q    <= long_d;
      step_q    <= step_d;
    end
  end

  assign press         = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign long_press    = long_q;
  assign step          = step_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed self-checking bench for button_conditioner with short cycle counts
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button = 1'b0;
  logic clean, press, release_pulse, repeat_pulse, long_press, step;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button       (button),
    .clean        (clean),
    .press        (press),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .long_press   (long_press),
    .step         (step)
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_press, n_release, n_repeat, n_step, n_clean;
  int rpt_q[$];
  int pcyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_press = 0;
    n_release = 0;
    n_repeat = 0;
    n_step = 0;
    n_clean = 0;
    rpt_q.delete();
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      n_press   += int'(press);
      n_release += int'(release_pulse);
      n_repeat  += int'(repeat_pulse);
      n_step    += int'(step);
      n_clean   += int'(clean);
      if (repeat_pulse) rpt_q.push_back(cyc);
    end
  endtask

  initial begin
    clr();
    step_n(2);
    chk("rst_clean", clean, 0);
    chk("rst_press", press, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_repeat", repeat_pulse, 0);
    chk("rst_long", long_press, 0);
    chk("rst_step", step, 0);
    reset = 1'b0;
    step_n(3);

    clr();
    button = 1'b1;
    step_n(5);
    chk("t1_pre_clean", clean, 0);
    chk("t1_pre_press_cnt", n_press, 0);
    step_n(1);
    chk("t1_press", press, 1);
    chk("t1_clean", clean, 1);
    chk("t1_step", step, 1);
    step_n(1);
    chk("t1_press_off", press, 0);
    chk("t1_step_off", step, 0);
    step_n(3);
    button = 1'b0;
    step_n(5);
    chk("t1_pre_release", release_pulse, 0);
    chk("t1_pre_rel_clean", clean, 1);
    step_n(1);
    chk("t1_release", release_pulse, 1);
    chk("t1_rel_clean", clean, 0);
    step_n(4);
    chk("t1_press_cnt", n_press, 1);
    chk("t1_release_cnt", n_release, 1);
    chk("t1_step_cnt", n_step, 1);
    chk("t1_repeat_cnt", n_repeat, 0);

    clr();
    button = 1'b1;
    step_n(1);
    button = 1'b0;
    step_n(1);
    button = 1'b1;
    step_n(1);
    button = 1'b0;
    step_n(1);
    button = 1'b1;
    step_n(5);
    chk("t2_bounce_press_cnt", n_press, 0);
    chk("t2_bounce_clean", clean, 0);
    step_n(1);
    chk("t2_press", press, 1);
    chk("t2_press_cnt", n_press, 1);
    button = 1'b0;
    step_n(8);
    chk("t2_release_cnt", n_release, 1);
    chk("t2_step_cnt", n_step, 1);

    clr();
    button = 1'b1;
    step_n(6);
    chk("t3_press", press, 1);
    pcyc = cyc;
    step_n(19);
    chk("t3_pre_repeat", repeat_pulse, 0);
    chk("t3_pre_long", long_press, 0);
    step_n(1);
    chk("t3_first_repeat", repeat_pulse, 1);
    chk("t3_long", long_press, 1);
    chk("t3_step_rpt", step, 1);
    step_n(40);
    chk("t3_repeat_60", repeat_pulse, 1);
    chk("t3_repeat_cnt", n_repeat, 6);
    chk("t3_step_cnt", n_step, 7);
    chk("t3_rpt_q_size", rpt_q.size(), 6);
    if (rpt_q.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("t3_rpt_at_%0d", i), rpt_q[i] - pcyc, 20 + 8 * i);

    step_n(10);
    button = 1'b0;
    step_n(5);
    chk("t4_pre_release", release_pulse, 0);
    chk("t4_pre_long", long_press, 1);
    step_n(1);
    chk("t4_release", release_pulse, 1);
    chk("t4_no_repeat", repeat_pulse, 0);
    chk("t4_clean", clean, 0);
    chk("t4_repeat_cnt", n_repeat, 7);
    step_n(1);
    chk("t4_long_cleared", long_press, 0);
    chk("t4_release_off", release_pulse, 0);
    chk("t4_no_late_repeat", repeat_pulse, 0);
    step_n(5);

    clr();
    button = 1'b1;
    step_n(6);
    chk("t5_press", press, 1);
    step_n(24);
    chk("t5_clean_held", clean, 1);
    reset = 1'b1;
    step_n(1);
    reset = 1'b0;
    chk("t5_rst_clean", clean, 0);
    chk("t5_rst_press", press, 0);
    chk("t5_rst_release", release_pulse, 0);
    chk("t5_rst_repeat", repeat_pulse, 0);
    chk("t5_rst_long", long_press, 0);
    chk("t5_rst_step", step, 0);
    clr();
    step_n(5);
    chk("t5_pre_repress", n_press, 0);
    chk("t5_pre_clean", clean, 0);
    step_n(1);
    chk("t5_repress", press, 1);
    button = 1'b0;
    step_n(10);

    clr();
    button = 1'b1;
    step_n(3);
    button = 1'b0;
    step_n(10);
    chk("t6_clean_cnt", n_clean, 0);
    chk("t6_press_cnt", n_press, 0);
    chk("t6_release_cnt", n_release, 0);
    chk("t6_repeat_cnt", n_repeat, 0);
    chk("t6_step_cnt", n_step, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
